// File: rtl/game_timer.sv
// rtl/game_timer.sv - prescaled up/down game timer with pause, done detection and optional auto-reload
// Optional lap capture ports are enabled by defining GAME_TIMER_LAP_EN.
module game_timer #(
    parameter int CLK_HZ      = 10_000_000,
    parameter int TICK_HZ     = 10,
    parameter int CNT_W       = 10,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CLOCK10M,
    input  logic             KEY0,
    input  logic             SWITCH0,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] load_val,
`ifdef GAME_TIMER_LAP_EN
    input  logic             lap,
    output logic [CNT_W-1:0] lap_out,
    output logic             lap_valid,
`endif
    output logic [CNT_W-1:0] counter_out,
    output logic             tick,
    output logic             running,
    output logic             done,
    output logic [1:0]       state_out
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_next;
    logic [CNT_W-1:0] limit_r;
    logic [CNT_W-1:0] limit_next;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] stepped;
    logic             dir_r;
    logic             dir_next;
    logic             tick_next;
    logic             done_next;
    logic             terminal;

    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            state       <= IDLE;
            pre         <= '0;
            limit_r     <= '0;
            dir_r       <= 1'b0;
            counter_out <= '0;
            tick        <= 1'b0;
            done        <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_next;
            pre         <= pre_next;
            limit_r     <= limit_next;
            dir_r       <= dir_next;
            counter_out <= cnt_next;
            tick        <= tick_next;
            done        <= done_next;
            running     <= (state_next == RUN);
        end
    end

    assign state_out = state;

    always_comb begin
        state_next = state;
        pre_next   = pre;
        limit_next = limit_r;
        dir_next   = dir_r;
        cnt_next   = counter_out;
        tick_next  = 1'b0;
        done_next  = done;
        stepped    = dir_r ? (counter_out - CNT_W'(1)) : (counter_out + CNT_W'(1));
        terminal   = dir_r ? (stepped == '0) : (stepped == limit_r);

        if (start) begin
            // Restart from any state; a tick falling on this edge is discarded.
            limit_next = load_val;
            dir_next   = dir;
            cnt_next   = dir ? load_val : '0;
            pre_next   = '0;
            done_next  = 1'b0;
            state_next = RUN;
            if (load_val == '0 && !AUTO_RELOAD) begin
                done_next  = 1'b1;
                state_next = DONE;
            end
        end else begin
            case (state)
                RUN, PAUSE: begin
                    done_next = 1'b0;
                    if (!SWITCH0) begin
                        state_next = PAUSE;
                    end else begin
                        // Resuming from PAUSE counts on the same edge so no prescaler phase is lost.
                        state_next = RUN;
                        if (limit_r != '0) begin
                            if (pre == PRE_LAST) begin
                                pre_next  = '0;
                                tick_next = 1'b1;
                                if (!terminal) begin
                                    cnt_next = stepped;
                                end else if (AUTO_RELOAD) begin
                                    cnt_next  = dir_r ? limit_r : '0;
                                    done_next = 1'b1;
                                end else begin
                                    cnt_next   = stepped;
                                    done_next  = 1'b1;
                                    state_next = DONE;
                                end
                            end else begin
                                pre_next = pre + PRE_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef GAME_TIMER_LAP_EN
    always_ff @(posedge CLOCK10M) begin
        if (KEY0) begin
            lap_out   <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= lap && !start && (state != IDLE);
            if (lap && !start && (state != IDLE)) begin
                lap_out <= counter_out;
            end
        end
    end
`endif

endmodule

// File: tb/tb_game_timer.sv
// tb/tb_game_timer.sv - scoreboard bench for game_timer, one-shot and auto-reload instances
module tb_game_timer;
    localparam int DIV = 10;

    typedef struct packed {
        logic [9:0] cnt;
        logic       tick;
        logic       run;
        logic       done;
        logic [1:0] st;
        logic [9:0] lapo;
        logic       lapv;
    } exp_t;

    logic       clk = 1'b0;
    logic       key0 = 1'b1;
    logic       sw = 1'b0;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic [9:0] load_val = '0;
    logic       lap_in = 1'b0;

    logic [9:0] cnt0, cnt1;
    logic       tick0, tick1, run0, run1, done0, done1;
    logic [1:0] st0, st1;
`ifdef GAME_TIMER_LAP_EN
    logic [9:0] lapo0, lapo1;
    logic       lapv0, lapv1;
`endif

    always #5 clk = ~clk;

    game_timer #(.CLK_HZ(100), .TICK_HZ(10), .CNT_W(10), .AUTO_RELOAD(1'b0)) dut0 (
        .CLOCK10M(clk), .KEY0(key0), .SWITCH0(sw), .start(start), .dir(dir), .load_val(load_val),
`ifdef GAME_TIMER_LAP_EN
        .lap(lap_in), .lap_out(lapo0), .lap_valid(lapv0),
`endif
        .counter_out(cnt0), .tick(tick0), .running(run0), .done(done0), .state_out(st0)
    );

    game_timer #(.CLK_HZ(100), .TICK_HZ(10), .CNT_W(10), .AUTO_RELOAD(1'b1)) dut1 (
        .CLOCK10M(clk), .KEY0(key0), .SWITCH0(sw), .start(start), .dir(dir), .load_val(load_val),
`ifdef GAME_TIMER_LAP_EN
        .lap(lap_in), .lap_out(lapo1), .lap_valid(lapv1),
`endif
        .counter_out(cnt1), .tick(tick1), .running(run1), .done(done1), .state_out(st1)
    );

    // Reference model: state is derived from active counting cycles since the last start.
    bit  m_started [2];
    bit  m_fin     [2];
    bit  m_dir     [2];
    bit  m_tick    [2];
    bit  m_done    [2];
    bit  m_lapv    [2];
    int  m_lim     [2];
    int  m_act     [2];
    int  m_cnt     [2];
    int  m_state   [2];
    int  m_lapo    [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    function automatic exp_t model_step(int k, bit rst, bit s, bit st, bit d, int lv, bit lp);
        exp_t e;
        bit   rl;
        int   ticks;
        int   prev_cnt;
        bit   prev_live;
        rl        = (k == 1);
        prev_cnt  = m_cnt[k];
        prev_live = m_started[k];
        m_tick[k] = 1'b0;
        m_lapv[k] = 1'b0;
        if (rst) begin
            m_started[k] = 1'b0;
            m_fin[k]     = 1'b0;
            m_cnt[k]     = 0;
            m_state[k]   = 0;
            m_done[k]    = 1'b0;
            m_lapo[k]    = 0;
        end else if (st) begin
            m_started[k] = 1'b1;
            m_lim[k]     = lv;
            m_dir[k]     = d;
            m_act[k]     = 0;
            m_cnt[k]     = d ? lv : 0;
            m_fin[k]     = (lv == 0) && !rl;
            m_done[k]    = m_fin[k];
            m_state[k]   = m_fin[k] ? 3 : 1;
        end else if (m_started[k] && !m_fin[k]) begin
            if (lp) begin
                m_lapv[k] = 1'b1;
                m_lapo[k] = prev_cnt;
            end
            m_done[k] = 1'b0;
            if (!s) begin
                m_state[k] = 2;
            end else begin
                m_state[k] = 1;
                if (m_lim[k] != 0) begin
                    m_act[k] = m_act[k] + 1;
                    if (m_act[k] % DIV == 0) begin
                        ticks     = m_act[k] / DIV;
                        m_tick[k] = 1'b1;
                        if (rl) begin
                            m_cnt[k]  = m_dir[k] ? m_lim[k] - (ticks % m_lim[k]) : ticks % m_lim[k];
                            m_done[k] = (ticks % m_lim[k] == 0);
                        end else begin
                            m_cnt[k] = m_dir[k] ? m_lim[k] - ticks : ticks;
                            if (ticks >= m_lim[k]) begin
                                m_fin[k]   = 1'b1;
                                m_done[k]  = 1'b1;
                                m_state[k] = 3;
                            end
                        end
                    end
                end
            end
        end else if (m_started[k] && lp && prev_live) begin
            m_lapv[k] = 1'b1;
            m_lapo[k] = prev_cnt;
        end
        e.cnt  = 10'(m_cnt[k]);
        e.tick = m_tick[k];
        e.run  = (m_state[k] == 1);
        e.done = m_done[k];
        e.st   = 2'(m_state[k]);
        e.lapo = 10'(m_lapo[k]);
        e.lapv = m_lapv[k];
        return e;
    endfunction

    task automatic step(input bit rst, input bit s, input bit st, input bit d, input int lv);
        @(negedge clk);
        cyc++;
        key0     = rst;
        sw       = s;
        start    = st;
        dir      = d;
        load_val = 10'(lv);
`ifdef GAME_TIMER_LAP_EN
        lap_in   = ($urandom_range(0, 3) == 0);
`endif
        q0.push_back(model_step(0, rst, s, st, d, lv, lap_in));
        q1.push_back(model_step(1, rst, s, st, d, lv, lap_in));
    endtask

    task automatic idle(input int n, input bit s);
        for (int i = 0; i < n; i++) step(1'b0, s, 1'b0, 1'b0, 0);
    endtask

    task automatic check(input string nm, input exp_t e, input logic [14:0] a);
        n_total++;
        if (a === {e.cnt, e.tick, e.run, e.done, e.st}) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d actual cnt=%0d tick=%0b run=%0b done=%0b st=%0b required cnt=%0d tick=%0b run=%0b done=%0b st=%0b",
                     nm, cyc, a[14:5], a[4], a[3], a[2], a[1:0], e.cnt, e.tick, e.run, e.done, e.st);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("oneshot", e, {cnt0, tick0, run0, done0, st0});
`ifdef GAME_TIMER_LAP_EN
                n_total++;
                if (lapv0 === e.lapv && lapo0 === e.lapo) n_pass++;
                else $display("FAIL lap0 cyc=%0d actual %0b/%0d required %0b/%0d", cyc, lapv0, lapo0, e.lapv, e.lapo);
`endif
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("reload", e, {cnt1, tick1, run1, done1, st1});
`ifdef GAME_TIMER_LAP_EN
                n_total++;
                if (lapv1 === e.lapv && lapo1 === e.lapo) n_pass++;
                else $display("FAIL lap1 cyc=%0d actual %0b/%0d required %0b/%0d", cyc, lapv1, lapo1, e.lapv, e.lapo);
`endif
            end
        end
    end

    initial begin : stimulus
        bit rst_r, st_r, sw_r, d_r;
        int lv_r;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(4, 1'b1);
        // Up to 5, then hold in DONE.
        step(1'b0, 1'b1, 1'b1, 1'b0, 5);
        idle(160, 1'b1);
        // Down from 3, then restart.
        step(1'b0, 1'b1, 1'b1, 1'b1, 3);
        idle(40, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3);
        idle(5, 1'b1);
        // Pause mid-run.
        step(1'b0, 1'b1, 1'b1, 1'b0, 5);
        idle(13, 1'b1);
        idle(20, 1'b0);
        idle(30, 1'b1);
        // Reset mid-run.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(5, 1'b1);
        // Reload pattern, zero limit, and start landing on a tick edge.
        step(1'b0, 1'b1, 1'b1, 1'b1, 2);
        idle(70, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 0);
        idle(25, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 2);
        idle(9, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4);
        idle(30, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3);
        idle(15, 1'b0);
        idle(40, 1'b1);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 299) == 0);
            st_r  = ($urandom_range(0, 59) == 0);
            sw_r  = ($urandom_range(0, 7) != 0);
            d_r   = 1'($urandom_range(0, 1));
            lv_r  = int'($urandom_range(0, 5));
            step(rst_r, sw_r, st_r, d_r, lv_r);
        end
        @(posedge clk);
        #3;
        n_total++;
        if (q0.size() == 0 && q1.size() == 0) n_pass++;
        else $display("FAIL drain actual %0d/%0d pending required 0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
